// File: rtl/legv8_ctrl_pipe.sv
// LEGv8 main control decoder behind a valid/ready handshake, carried through LAT register stages.
// Latency: LAT edges from acceptance to out_valid. Backpressure: all stages freeze while out_valid && !out_ready.
// Optional: define CTRL_ILLEGAL_TRAP_EN to add a TRAP state entered on acceptance of an illegal opcode.
module legv8_ctrl_pipe #(
  parameter int LAT   = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      inst31_21,
  input  logic             resume,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Reg2Loc,
  output logic             Branch,
  output logic             BranchZero,
  output logic             BranchNonZero,
  output logic             MemRead,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrc,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic             trap
);

  // Bundle layout: {Reg2Loc, Branch, BranchZero, BranchNonZero, MemRead, MemtoReg,
  //                 MemWrite, RegWrite, ALUOp[1:0], ALUSrc[1:0], illegal}
  localparam int BW = 13;
  localparam logic [BW-1:0] BUN_LDUR = 13'b0_0_0_0_1_1_0_1_00_01_0;
  localparam logic [BW-1:0] BUN_STUR = 13'b1_0_0_0_0_0_1_0_00_01_0;
  localparam logic [BW-1:0] BUN_RTYP = 13'b0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [BW-1:0] BUN_ADDI = 13'b0_0_0_0_0_0_0_1_10_10_0;
  localparam logic [BW-1:0] BUN_CBZ  = 13'b1_0_1_0_0_0_0_0_01_00_0;
  localparam logic [BW-1:0] BUN_CBNZ = 13'b1_0_0_1_0_0_0_0_01_00_0;
  localparam logic [BW-1:0] BUN_B    = 13'b0_1_0_0_0_0_0_0_00_00_0;
  localparam logic [BW-1:0] BUN_ILL  = 13'b0_0_0_0_0_0_0_0_00_00_1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_TRAP} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           dec_bun;
  logic                    dec_halt;
  logic                    advance;
  logic                    accept;
  logic [LAT-1:0]          vld_q;
  logic [LAT-1:0][BW-1:0]  bun_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]           out_bun;

  // Opcode decode, narrowest match wins: full opcode, then [10:1], [10:3], [10:5]
  always_comb begin
    dec_bun  = '0;
    dec_halt = 1'b0;
    if (inst31_21 == 11'b11010101000)            dec_bun = '0;
    else if (inst31_21 == 11'b11111000010)       dec_bun = BUN_LDUR;
    else if (inst31_21 == 11'b11111000000)       dec_bun = BUN_STUR;
    else if (inst31_21 == 11'b10001011000 ||
             inst31_21 == 11'b11001011000 ||
             inst31_21 == 11'b10001010000 ||
             inst31_21 == 11'b10101010000)       dec_bun = BUN_RTYP;
    else if (inst31_21 == 11'b11111111111)       dec_halt = 1'b1;
    else if (inst31_21[10:1] == 10'b1001000100)  dec_bun = BUN_ADDI;
    else if (inst31_21[10:3] == 8'b10110100)     dec_bun = BUN_CBZ;
    else if (inst31_21[10:3] == 8'b10110101)     dec_bun = BUN_CBNZ;
    else if (inst31_21[10:5] == 6'b000101)       dec_bun = BUN_B;
    else                                         dec_bun = BUN_ILL;
  end

  assign out_valid = vld_q[LAT-1];
  assign advance   = out_ready || !out_valid;
  assign accept    = in_valid && in_ready;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // FSM next state: HALT (or illegal, when trapping) stops intake until resume
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (accept && dec_halt) state_d = S_HALTED;
`ifdef CTRL_ILLEGAL_TRAP_EN
        else if (accept && dec_bun[0]) state_d = S_TRAP;
`endif
      end
      S_HALTED: if (resume) state_d = S_RUN;
      S_TRAP:   if (resume) state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
  end

  // FSM outputs: intake only in RUN and only when the pipe can shift
  always_comb begin
    in_ready = advance && (state_q == S_RUN);
    halted   = (state_q == S_HALTED);
`ifdef CTRL_ILLEGAL_TRAP_EN
    trap     = (state_q == S_TRAP);
`else
    trap     = 1'b0;
`endif
  end

  // Pipeline stages: shift together on advance, otherwise hold for a stable stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      bun_q <= '0;
    end else if (advance) begin
      vld_q[0] <= accept;
      bun_q[0] <= dec_bun;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        bun_q[i] <= bun_q[i-1];
      end
    end
  end

  // Illegal counter next value: saturates at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_bun[0] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_ONE;
  end

  // Illegal counter register, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign illegal_cnt = cnt_q;
  assign out_bun     = out_valid ? bun_q[LAT-1] : '0;
  assign {Reg2Loc, Branch, BranchZero, BranchNonZero, MemRead, MemtoReg,
          MemWrite, RegWrite, ALUOp, ALUSrc, illegal} = out_bun;

endmodule
